// File: rtl/mssd_pkg.sv
// Shared types and sizes for the serial frame controller.
package mssd_pkg;
  typedef enum logic [1:0] {IDLE, DEST, LEN, DATA} state_t;
  localparam int DEST_W    = 2;
  localparam int NUM_PORTS = 4;
  localparam int DEF_LEN_W = 4;
endpackage

// File: rtl/mssd_frame_controller_if.sv
// Serial line, port enables and datapath steering outputs of the frame controller.
interface mssd_frame_controller_if;
  import mssd_pkg::*;
  logic                 serIn;
  logic [NUM_PORTS-1:0] port_en;
  logic [DEST_W-1:0]    d;
  logic                 dataCom;
  logic                 busy;
  logic                 done;
  logic                 drop;

  modport master (output serIn, port_en, input d, dataCom, busy, done, drop);
  modport slave  (input serIn, port_en, output d, dataCom, busy, done, drop);
endinterface

// File: rtl/mssd_bit_counter.sv
// Loadable down-counter with zero flag; shared by field and payload counting.
module mssd_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)     cnt_q <= '0;
    else if (load) cnt_q <= load_val;
    else if (dec)  cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/mssd_frame_controller.sv
// Frame parser: start bit, 2-bit destination, length field, then steers N payload bits.
// state | meaning
// IDLE  | waiting for a start bit (only once the line has been seen high)
// DEST  | shifting in the destination field
// LEN   | shifting in the length field
// DATA  | payload on the line; dataCom high if the port is enabled
module mssd_frame_controller #(
  parameter int LEN_W = mssd_pkg::DEF_LEN_W
) (
  input logic                   clk,
  input logic                   reset,
  mssd_frame_controller_if.slave bus
);
  import mssd_pkg::*;

  state_t            state_q, state_n;
  logic              armed_q, armed_n;
  logic              pend_q, pend_n;
  logic [DEST_W-1:0] dest_q, dest_n, d_q, d_n;
  logic [LEN_W-1:0]  len_q, len_n, cnt_val;
  logic              dc_q, dc_n, done_q, done_n, drop_q, drop_n;
  logic              cnt_load, cnt_dec, cnt_zero;

  mssd_bit_counter #(.W(LEN_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      pend_q  <= 1'b0;
      dest_q  <= '0;
      len_q   <= '0;
      d_q     <= '0;
      dc_q    <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      armed_q <= armed_n;
      pend_q  <= pend_n;
      dest_q  <= dest_n;
      len_q   <= len_n;
      d_q     <= d_n;
      dc_q    <= dc_n;
      done_q  <= done_n;
      drop_q  <= drop_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (armed_q && !bus.serIn) state_n = DEST;
      DEST:    if (cnt_zero) state_n = LEN;
      LEN:     if (cnt_zero) state_n = DATA;
      DATA:    if (cnt_zero) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    armed_n  = armed_q;
    pend_n   = pend_q;
    dest_n   = dest_q;
    len_n    = len_q;
    d_n      = d_q;
    dc_n     = dc_q;
    done_n   = 1'b0;
    drop_n   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state_q)
      IDLE: begin
        if (bus.serIn) begin
          armed_n = 1'b1;
        end else if (armed_q) begin
          cnt_load = 1'b1;
          cnt_val  = LEN_W'(1);
        end
      end
      DEST: begin
        dest_n = {dest_q[DEST_W-2:0], bus.serIn};
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = LEN_W'(LEN_W - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      LEN: begin
        len_n = {len_q[LEN_W-2:0], bus.serIn};
        if (cnt_zero) begin
          // Payload count is the raw field, so N = field + 1 edges in DATA.
          cnt_load = 1'b1;
          cnt_val  = len_n;
          if (bus.port_en[dest_q]) begin
            d_n  = dest_q;
            dc_n = 1'b1;
          end else begin
            pend_n = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DATA: begin
        if (cnt_zero) begin
          dc_n   = 1'b0;
          done_n = !pend_q;
          drop_n = pend_q;
          pend_n = 1'b0;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.d       = d_q;
  assign bus.dataCom = dc_q;
  assign bus.done    = done_q;
  assign bus.drop    = drop_q;
  assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_mssd_frame_controller.sv
// Directed frame table, corner-case sequences and a randomized schedule-based check.
module tb_mssd_frame_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mssd_frame_controller_if bus();
  mssd_frame_controller #(.LEN_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          gap;
    logic [1:0]  dest;
    logic [3:0]  lenf;
    logic [15:0] payload;
    logic [3:0]  pe;
    logic        exp_dc;
    logic [1:0]  exp_d;
    logic        exp_done;
    logic        exp_drop;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // inputs for the next edge, then observe #1 after it
  task automatic tick(input logic r, input logic s, input logic [3:0] pe);
    reset = r;
    bus.serIn = s;
    bus.port_en = pe;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] outs4();
    return {bus.busy, bus.dataCom, bus.done, bus.drop};
  endfunction

  // port_en is inverted everywhere except the edge that samples it
  task automatic send_frame(input vec_t v, input string tag);
    logic [3:0] pe_x;
    logic [5:0] hdr;
    int n;
    pe_x = ~v.pe;
    hdr  = {v.dest, v.lenf};
    n    = int'(v.lenf) + 1;
    for (int g = 0; g < v.gap; g++) tick(1'b0, 1'b1, pe_x);
    chk({tag, ".dc_before_start"}, 32'(bus.dataCom), 0);
    tick(1'b0, 1'b0, pe_x);
    chk({tag, ".busy_after_start"}, 32'(bus.busy), 1);
    for (int i = 5; i >= 0; i--) begin
      chk({tag, ".dc_in_header"}, 32'(bus.dataCom), 0);
      tick(1'b0, hdr[i], (i == 0) ? v.pe : pe_x);
    end
    chk({tag, ".pulses_in_header"}, 32'({bus.done, bus.drop}), 0);
    for (int k = n - 1; k >= 0; k--) begin
      chk({tag, ".dc_payload"}, 32'(bus.dataCom), 32'(v.exp_dc));
      if (v.exp_dc) chk({tag, ".d_payload"}, 32'(bus.d), 32'(v.exp_d));
      chk({tag, ".busy_payload"}, 32'(bus.busy), 1);
      tick(1'b0, v.payload[k], pe_x);
    end
    chk({tag, ".end_outs"}, 32'(outs4()), 32'({1'b0, 1'b0, v.exp_done, v.exp_drop}));
    chk({tag, ".end_d"}, 32'(bus.d), 32'(v.exp_d));
  endtask

  vec_t tbl[5];
  vec_t vr;

  logic       rst_s[1024];
  logic       ser_s[1024];
  logic [3:0] pe_s[1024];
  logic [3:0] exp_o[1024];
  logic [1:0] exp_d[1024];
  int         fs[30], fn[30];
  logic [1:0] fd[30];

  initial begin
    tbl[0] = '{3, 2'b10, 4'h2, 16'h0005, 4'b1011, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[1] = '{3, 2'b10, 4'h2, 16'h0005, 4'hF,    1'b1, 2'b10, 1'b1, 1'b0};
    tbl[2] = '{0, 2'b01, 4'h0, 16'h0001, 4'hF,    1'b1, 2'b01, 1'b1, 1'b0};
    tbl[3] = '{0, 2'b11, 4'hF, 16'hA5C3, 4'hF,    1'b1, 2'b11, 1'b1, 1'b0};
    tbl[4] = '{1, 2'b00, 4'h5, 16'h002A, 4'b1110, 1'b0, 2'b11, 1'b0, 1'b1};

    tick(1'b1, 1'b1, 4'hF);
    tick(1'b1, 1'b1, 4'hF);
    chk("reset.outs", 32'(outs4()), 0);
    chk("reset.d", 32'(bus.d), 0);

    for (int i = 0; i < 5; i++) send_frame(tbl[i], $sformatf("tbl%0d", i));

    // reset during the 2nd bit of a 5-bit payload, then 0,0 must not start a frame
    tick(1'b0, 1'b1, 4'hF);
    tick(1'b0, 1'b0, 4'hF);
    begin
      logic [5:0] h;
      h = {2'b01, 4'h4};
      for (int i = 5; i >= 0; i--) tick(1'b0, h[i], 4'hF);
    end
    tick(1'b0, 1'b1, 4'hF);
    chk("rstmid.dc_cycle2", 32'(bus.dataCom), 1);
    tick(1'b1, 1'b1, 4'hF);
    chk("rstmid.outs", 32'(outs4()), 0);
    chk("rstmid.d", 32'(bus.d), 0);
    tick(1'b0, 1'b0, 4'hF);
    chk("rstmid.no_start0", 32'(outs4()), 0);
    tick(1'b0, 1'b0, 4'hF);
    chk("rstmid.no_start1", 32'(outs4()), 0);
    tick(1'b0, 1'b1, 4'hF);
    chk("rstmid.idle", 32'(outs4()), 0);
    vr = '{1, 2'b11, 4'h1, 16'h0002, 4'hF, 1'b1, 2'b11, 1'b1, 1'b0};
    send_frame(vr, "rstmid.next");

    for (int i = 0; i < 50; i++) begin
      tick(1'b0, 1'b1, 4'($urandom));
      chk("idle.outs", 32'(outs4()), 0);
    end

    // randomized stream; expectations derived from each frame's start position
    begin
      int len, nf;
      len = 0;
      nf  = 30;
      for (int i = 0; i < 2; i++) begin
        rst_s[len] = 1'b1; ser_s[len] = 1'b1; pe_s[len] = 4'($urandom); len++;
      end
      for (int f = 0; f < nf; f++) begin
        int gap;
        logic [5:0] h;
        logic [3:0] lf;
        gap = (f == 0) ? 1 + $urandom_range(2) : $urandom_range(3);
        for (int g = 0; g < gap; g++) begin
          rst_s[len] = 1'b0; ser_s[len] = 1'b1; pe_s[len] = 4'($urandom); len++;
        end
        fd[f] = 2'($urandom_range(3));
        lf    = ($urandom_range(3) == 0) ? 4'hF : 4'($urandom);
        fn[f] = int'(lf) + 1;
        fs[f] = len;
        rst_s[len] = 1'b0; ser_s[len] = 1'b0; pe_s[len] = 4'($urandom); len++;
        h = {fd[f], lf};
        for (int i = 5; i >= 0; i--) begin
          rst_s[len] = 1'b0; ser_s[len] = h[i]; pe_s[len] = 4'($urandom); len++;
        end
        for (int k = 0; k < fn[f]; k++) begin
          rst_s[len] = 1'b0; ser_s[len] = 1'($urandom); pe_s[len] = 4'($urandom); len++;
        end
      end
      for (int i = 0; i < 3; i++) begin
        rst_s[len] = 1'b0; ser_s[len] = 1'b1; pe_s[len] = 4'($urandom); len++;
      end
      for (int i = 0; i < len; i++) begin
        exp_o[i] = 4'b0;
        exp_d[i] = 2'b00;
      end
      for (int f = 0; f < nf; f++) begin
        int s, n;
        logic en;
        s  = fs[f];
        n  = fn[f];
        en = pe_s[s + 6][fd[f]];
        for (int i = s; i <= s + 5 + n; i++) exp_o[i][3] = 1'b1;
        if (en) begin
          for (int i = s + 6; i <= s + 5 + n; i++) exp_o[i][2] = 1'b1;
          for (int i = s + 6; i < len; i++) exp_d[i] = fd[f];
          exp_o[s + 6 + n][1] = 1'b1;
        end else begin
          exp_o[s + 6 + n][0] = 1'b1;
        end
      end
      for (int i = 0; i < len; i++) begin
        tick(rst_s[i], ser_s[i], pe_s[i]);
        chk($sformatf("rand.cyc%0d", i), 32'({outs4(), bus.d}), 32'({exp_o[i], exp_d[i]}));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
